// File: rtl/wb_periph_fabric.sv
// wb_periph_fabric: Wishbone fabric between the core read/write channels
// and NUM_SLAVES peripherals.
//  - address-decoded one-hot strobe fan-out; slave index = adr[ADDR_BITS-1:SLV_ADDR_BITS]
//  - per-channel ack timeout, unmapped-address and timeout errors answered
//    with an ack pulse plus bus_err_o, address/direction of the last error captured
//  - masked, registered interrupt aggregation into int_gen_o
// Ports:
//  clk, reset_n (async low), sync_reset (sync high, same effect)
//  rd_stb_i/rd_adr_i -> rd_dat_o/rd_ack_o                  read channel
//  wr_stb_i/wr_sel_i/wr_adr_i/wr_dat_i -> wr_ack_o          write channel
//  s_rd_stb_o/s_rd_adr_o <- s_rd_dat_i/s_rd_ack_i           slave read side
//  s_wr_stb_o/s_wr_sel_o/s_wr_adr_o/s_wr_dat_o <- s_wr_ack_i slave write side
//  s_int_i -> int_gen_o; bus_err_o, err_adr_o, err_is_wr_o  error report

// One channel: IDLE/WAIT/DONE sequencer with decode and ack timer.
// fin_ok_o / fin_err_o are combinational "channel completes at this edge"
// flags; the top registers them into the master ack and error report.
module wb_fabric_chan #(
  parameter int ADDR_BITS      = 8,
  parameter int SLV_ADDR_BITS  = 4,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_reset,
  input  logic                  stb_i,
  input  logic [ADDR_BITS-1:0]  adr_i,
  input  logic [NUM_SLAVES-1:0] s_ack_i,
  output logic [NUM_SLAVES-1:0] s_stb_o,
  output logic                  accept_o,
  output logic                  fin_ok_o,
  output logic                  fin_err_o,
  output logic [ADDR_BITS-1:0]  fin_adr_o
);
  localparam int IDXW = ADDR_BITS - SLV_ADDR_BITS;
  localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDXW:0] NUM_W = (IDXW+1)'(NUM_SLAVES);
  localparam logic [CW-1:0] TO_W  = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  adr_q, adr_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [NUM_SLAVES-1:0] s_stb_q, s_stb_d;

  logic [IDXW-1:0]       idx_in;
  logic [NUM_SLAVES-1:0] oh_in;
  logic                  mapped, accept, hit, timeout;

  always_comb begin
    idx_in = adr_i[ADDR_BITS-1:SLV_ADDR_BITS];
    mapped = {1'b0, idx_in} < NUM_W;
    oh_in  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) oh_in[k] = (idx_in == IDXW'(k));

    // DONE behaves like IDLE for a new strobe; a strobe during WAIT is dropped
    accept  = stb_i && (state_q != ST_WAIT);
    hit     = (state_q == ST_WAIT) && |(s_ack_i & sel_q);
    timeout = (state_q == ST_WAIT) && !hit && (cnt_q == TO_W);

    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    s_stb_d = '0;

    if (accept) begin
      adr_d   = adr_i;
      sel_d   = mapped ? oh_in : '0;
      s_stb_d = mapped ? oh_in : '0;
      cnt_d   = mapped ? CW'(1) : '0;
      state_d = mapped ? ST_WAIT : ST_DONE;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (hit || timeout) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (sync_reset) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      adr_d   = '0;
      sel_d   = '0;
      s_stb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      s_stb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      s_stb_q <= s_stb_d;
    end
  end

  assign s_stb_o   = s_stb_q;
  assign accept_o  = accept;
  assign fin_ok_o  = hit;
  assign fin_err_o = timeout || (accept && !mapped);
  // unmapped errors finish in the accept cycle, before adr_q holds the address
  assign fin_adr_o = accept ? adr_i : adr_q;
endmodule

module wb_periph_fabric #(
  parameter int                   XLEN           = 32,
  parameter int                   ADDR_BITS      = 8,
  parameter int                   SLV_ADDR_BITS  = 4,
  parameter int                   NUM_SLAVES     = 4,
  parameter int                   TIMEOUT_CYCLES = 15,
  parameter logic [XLEN-1:0]       ERR_DATA       = 32'hDEADBEEF,
  parameter logic [NUM_SLAVES-1:0] INT_EN         = {NUM_SLAVES{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sync_reset,
  input  logic                       rd_stb_i,
  input  logic [ADDR_BITS-1:0]       rd_adr_i,
  output logic [XLEN-1:0]            rd_dat_o,
  output logic                       rd_ack_o,
  input  logic                       wr_stb_i,
  input  logic [XLEN/8-1:0]          wr_sel_i,
  input  logic [ADDR_BITS-1:0]       wr_adr_i,
  input  logic [XLEN-1:0]            wr_dat_i,
  output logic                       wr_ack_o,
  output logic [NUM_SLAVES-1:0]      s_rd_stb_o,
  output logic [SLV_ADDR_BITS-1:0]   s_rd_adr_o,
  input  logic [NUM_SLAVES*XLEN-1:0] s_rd_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_rd_ack_i,
  output logic [NUM_SLAVES-1:0]      s_wr_stb_o,
  output logic [XLEN/8-1:0]          s_wr_sel_o,
  output logic [SLV_ADDR_BITS-1:0]   s_wr_adr_o,
  output logic [XLEN-1:0]            s_wr_dat_o,
  input  logic [NUM_SLAVES-1:0]      s_wr_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_int_i,
  output logic                       int_gen_o,
  output logic                       bus_err_o,
  output logic [ADDR_BITS-1:0]       err_adr_o,
  output logic                       err_is_wr_o
);
  localparam int NCH = 2;  // channel 0 = read, channel 1 = write

  logic [NCH-1:0]                  ch_stb, ch_acc, ch_ok, ch_err;
  logic [NCH-1:0][ADDR_BITS-1:0]   ch_adr, ch_fadr;
  logic [NCH-1:0][NUM_SLAVES-1:0]  ch_sack, ch_sstb;

  assign ch_stb  = {wr_stb_i, rd_stb_i};
  assign ch_adr  = {wr_adr_i, rd_adr_i};
  assign ch_sack = {s_wr_ack_i, s_rd_ack_i};

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    wb_fabric_chan #(
      .ADDR_BITS      (ADDR_BITS),
      .SLV_ADDR_BITS  (SLV_ADDR_BITS),
      .NUM_SLAVES     (NUM_SLAVES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .sync_reset (sync_reset),
      .stb_i      (ch_stb[c]),
      .adr_i      (ch_adr[c]),
      .s_ack_i    (ch_sack[c]),
      .s_stb_o    (ch_sstb[c]),
      .accept_o   (ch_acc[c]),
      .fin_ok_o   (ch_ok[c]),
      .fin_err_o  (ch_err[c]),
      .fin_adr_o  (ch_fadr[c])
    );
  end

  logic [NCH-1:0]                    ack_q, ack_d;
  logic [NCH-1:0][SLV_ADDR_BITS-1:0] off_q, off_d;
  logic [XLEN/8-1:0]                 wsel_q, wsel_d;
  logic [XLEN-1:0]                   wdat_q, wdat_d;
  logic [NUM_SLAVES-1:0]             rsel_q, rsel_d;
  logic [XLEN-1:0]                   rdat_q, rdat_d;
  logic                              bus_err_q, bus_err_d;
  logic [ADDR_BITS-1:0]              err_adr_q, err_adr_d;
  logic                              err_wr_q, err_wr_d;
  logic                              int_q, int_d;

  logic [NUM_SLAVES-1:0]             rd_oh;
  logic [XLEN-1:0]                   rd_mux;

  always_comb begin
    // read-data select: the strobe itself covers an ack in the strobe cycle,
    // afterwards the remembered one-hot target is used
    rd_oh  = (|ch_sstb[0]) ? ch_sstb[0] : rsel_q;
    rd_mux = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (rd_oh[k]) rd_mux = rd_mux | s_rd_dat_i[k*XLEN +: XLEN];

    ack_d     = ch_ok | ch_err;
    off_d     = off_q;
    wsel_d    = wsel_q;
    wdat_d    = wdat_q;
    rsel_d    = rsel_q;
    rdat_d    = rdat_q;
    bus_err_d = |ch_err;
    err_adr_d = err_adr_q;
    err_wr_d  = err_wr_q;
    int_d     = |(s_int_i & INT_EN);

    for (int c = 0; c < NCH; c++)
      if (ch_acc[c]) off_d[c] = ch_adr[c][SLV_ADDR_BITS-1:0];
    if (ch_acc[1]) begin
      wsel_d = wr_sel_i;
      wdat_d = wr_dat_i;
    end
    if (|ch_sstb[0]) rsel_d = ch_sstb[0];

    if (ch_ok[0])       rdat_d = rd_mux;
    else if (ch_err[0]) rdat_d = ERR_DATA;

    // simultaneous errors: read side owns the capture
    if (ch_err[0]) begin
      err_adr_d = ch_fadr[0];
      err_wr_d  = 1'b0;
    end else if (ch_err[1]) begin
      err_adr_d = ch_fadr[1];
      err_wr_d  = 1'b1;
    end

    if (sync_reset) begin
      ack_d     = '0;
      off_d     = '0;
      wsel_d    = '0;
      wdat_d    = '0;
      rsel_d    = '0;
      rdat_d    = '0;
      bus_err_d = 1'b0;
      err_adr_d = '0;
      err_wr_d  = 1'b0;
      int_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q     <= '0;
      off_q     <= '0;
      wsel_q    <= '0;
      wdat_q    <= '0;
      rsel_q    <= '0;
      rdat_q    <= '0;
      bus_err_q <= 1'b0;
      err_adr_q <= '0;
      err_wr_q  <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      off_q     <= off_d;
      wsel_q    <= wsel_d;
      wdat_q    <= wdat_d;
      rsel_q    <= rsel_d;
      rdat_q    <= rdat_d;
      bus_err_q <= bus_err_d;
      err_adr_q <= err_adr_d;
      err_wr_q  <= err_wr_d;
      int_q     <= int_d;
    end
  end

  assign rd_ack_o    = ack_q[0];
  assign wr_ack_o    = ack_q[1];
  assign rd_dat_o    = rdat_q;
  assign s_rd_stb_o  = ch_sstb[0];
  assign s_wr_stb_o  = ch_sstb[1];
  assign s_rd_adr_o  = off_q[0];
  assign s_wr_adr_o  = off_q[1];
  assign s_wr_sel_o  = wsel_q;
  assign s_wr_dat_o  = wdat_q;
  assign bus_err_o   = bus_err_q;
  assign err_adr_o   = err_adr_q;
  assign err_is_wr_o = err_wr_q;
  assign int_gen_o   = int_q;
endmodule

// File: tb/tb_wb_periph_fabric.sv
module tb_wb_periph_fabric;
  logic         clk = 1'b0;
  logic         reset_n, sync_reset;
  logic         rd_stb_i, wr_stb_i;
  logic [7:0]   rd_adr_i, wr_adr_i;
  logic [31:0]  rd_dat_o, wr_dat_i, s_wr_dat_o;
  logic         rd_ack_o, wr_ack_o;
  logic [3:0]   wr_sel_i, s_wr_sel_o;
  logic [3:0]   s_rd_stb_o, s_wr_stb_o, s_rd_adr_o, s_wr_adr_o;
  logic [127:0] s_rd_dat_i;
  logic [3:0]   s_rd_ack_i, s_wr_ack_i, s_int_i;
  logic         int_gen_o, bus_err_o, err_is_wr_o;
  logic [7:0]   err_adr_o;

  localparam logic [3:0] IEN = 4'b1011;
  localparam int         TO  = 15;

  wb_periph_fabric #(.INT_EN(IEN)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .rd_stb_i(rd_stb_i), .rd_adr_i(rd_adr_i), .rd_dat_o(rd_dat_o), .rd_ack_o(rd_ack_o),
    .wr_stb_i(wr_stb_i), .wr_sel_i(wr_sel_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
    .wr_ack_o(wr_ack_o),
    .s_rd_stb_o(s_rd_stb_o), .s_rd_adr_o(s_rd_adr_o), .s_rd_dat_i(s_rd_dat_i),
    .s_rd_ack_i(s_rd_ack_i),
    .s_wr_stb_o(s_wr_stb_o), .s_wr_sel_o(s_wr_sel_o), .s_wr_adr_o(s_wr_adr_o),
    .s_wr_dat_o(s_wr_dat_o), .s_wr_ack_i(s_wr_ack_i),
    .s_int_i(s_int_i), .int_gen_o(int_gen_o), .bus_err_o(bus_err_o),
    .err_adr_o(err_adr_o), .err_is_wr_o(err_is_wr_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic is_wr; logic [7:0] adr; logic [3:0] exp_stb; logic exp_err; } dec_vec_t;
  typedef struct { logic [3:0] irq; logic exp; } int_vec_t;
  dec_vec_t dvec[6];
  int_vec_t ivec[8];

  // reference-model state for the randomized phase
  bit          pend[2], mapd[2], eerr[2];
  int          t0[2], due[2], ackc[2], late[2], slv[2];
  logic [7:0]  eadr[2];
  logic [31:0] m_rdat, edat, m_wdat, ev;
  logic [3:0]  m_roff, m_woff, m_wsel, m_noise, irq;
  logic [7:0]  m_eadr;
  logic        m_ewr;
  int          cyc, nacks;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in;
    rd_stb_i = 0; wr_stb_i = 0; s_rd_ack_i = '0; s_wr_ack_i = '0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {rd_ack_o, wr_ack_o, bus_err_o, int_gen_o, err_is_wr_o,
                       s_rd_stb_o, s_wr_stb_o, s_rd_adr_o, s_wr_adr_o, s_wr_sel_o}, 0);
    chk({nm, "_dat"}, {rd_dat_o, s_wr_dat_o}, 0);
    chk({nm, "_eadr"}, err_adr_o, 0);
  endtask

  initial begin
    dvec[0] = '{1'b0, 8'h00, 4'b0001, 1'b0};
    dvec[1] = '{1'b0, 8'h3F, 4'b1000, 1'b0};
    dvec[2] = '{1'b1, 8'h2A, 4'b0100, 1'b0};
    dvec[3] = '{1'b1, 8'h40, 4'b0000, 1'b1};
    dvec[4] = '{1'b0, 8'hFF, 4'b0000, 1'b1};
    dvec[5] = '{1'b1, 8'h1F, 4'b0010, 1'b0};
    ivec[0] = '{4'b0100, 1'b0}; ivec[1] = '{4'b0001, 1'b1};
    ivec[2] = '{4'b0000, 1'b0}; ivec[3] = '{4'b1000, 1'b1};
    ivec[4] = '{4'b0010, 1'b1}; ivec[5] = '{4'b0100, 1'b0};
    ivec[6] = '{4'b1111, 1'b1}; ivec[7] = '{4'b0101, 1'b1};

    reset_n = 0; sync_reset = 0; idle_in();
    rd_adr_i = 0; wr_adr_i = 0; wr_sel_i = 0; wr_dat_i = 0; s_rd_dat_i = '0; s_int_i = 0;
    tick(); tick();
    chk_zero("reset");
    reset_n = 1;
    tick();

    // read to slave 2 offset 3, ack two cycles after the strobe cycle
    rd_stb_i = 1; rd_adr_i = 8'h23;
    tick(); rd_stb_i = 0;
    chk("t1_stb", s_rd_stb_o, 4'b0100);
    chk("t1_off", s_rd_adr_o, 3);
    tick();
    chk("t1_stb_off", s_rd_stb_o, 0);
    chk("t1_noack", rd_ack_o, 0);
    s_rd_ack_i = 4'b0100; s_rd_dat_i[64 +: 32] = 32'h1234_5678;
    tick(); s_rd_ack_i = 0;
    chk("t1_ack", rd_ack_o, 1);
    chk("t1_dat", rd_dat_o, 32'h1234_5678);
    chk("t1_berr", bus_err_o, 0);
    tick();
    chk("t1_ack_pulse", rd_ack_o, 0);
    chk("t1_dat_hold", rd_dat_o, 32'h1234_5678);

    // concurrent write and read to slave 1
    wr_stb_i = 1; wr_adr_i = 8'h10; wr_sel_i = 4'b0011; wr_dat_i = 32'hA5A5;
    rd_stb_i = 1; rd_adr_i = 8'h11;
    tick(); idle_in();
    chk("t2_wstb", s_wr_stb_o, 4'b0010);
    chk("t2_rstb", s_rd_stb_o, 4'b0010);
    chk("t2_wfld", {s_wr_sel_o, s_wr_adr_o, s_wr_dat_o}, {4'b0011, 4'h0, 32'hA5A5});
    chk("t2_roff", s_rd_adr_o, 1);
    s_wr_ack_i = 4'b0010;
    tick(); s_wr_ack_i = 0;
    chk("t2_wack", {wr_ack_o, rd_ack_o}, 2'b10);
    s_rd_ack_i = 4'b0010; s_rd_dat_i[32 +: 32] = 32'hCAFE_0001;
    tick(); s_rd_ack_i = 0;
    chk("t2_rack", {wr_ack_o, rd_ack_o}, 2'b01);
    chk("t2_rdat", rd_dat_o, 32'hCAFE_0001);

    // read timeout, then a late ack that must be ignored
    rd_stb_i = 1; rd_adr_i = 8'h15;
    tick(); rd_stb_i = 0;
    nacks = 0;
    for (int i = 1; i <= TO - 1; i++) begin
      nacks += rd_ack_o + bus_err_o;
      tick();
    end
    chk("t3_early_ack", nacks, 0);
    chk("t3_last_wait", rd_ack_o, 0);
    tick();
    chk("t3_ack", rd_ack_o, 1);
    chk("t3_dat", rd_dat_o, 32'hDEADBEEF);
    chk("t3_err", {bus_err_o, err_adr_o, err_is_wr_o}, {1'b1, 8'h15, 1'b0});
    tick();
    chk("t3_err_pulse", {bus_err_o, rd_ack_o}, 0);
    tick(); tick(); tick();
    s_rd_ack_i = 4'b0010;
    tick(); s_rd_ack_i = 0;
    chk("t3_late", {rd_ack_o, bus_err_o}, 0);

    // unmapped write
    wr_stb_i = 1; wr_adr_i = 8'h70; wr_sel_i = 4'hF; wr_dat_i = 32'h0BAD_0BAD;
    tick(); wr_stb_i = 0;
    chk("t4_nostb", s_wr_stb_o, 0);
    chk("t4_ack", {wr_ack_o, bus_err_o, err_is_wr_o, err_adr_o}, {3'b111, 8'h70});
    tick();

    // simultaneous unmapped read and write: one error pulse, read captured
    rd_stb_i = 1; rd_adr_i = 8'h80; wr_stb_i = 1; wr_adr_i = 8'h90;
    tick(); idle_in();
    chk("dual_ack", {rd_ack_o, wr_ack_o, bus_err_o}, 3'b111);
    chk("dual_cap", {err_adr_o, err_is_wr_o}, {8'h80, 1'b0});
    tick();
    chk("dual_pulse", bus_err_o, 0);

    // strobe during WAIT is dropped
    rd_stb_i = 1; rd_adr_i = 8'h01;
    tick(); rd_stb_i = 0;
    tick(); rd_stb_i = 1; rd_adr_i = 8'h02;
    tick(); rd_stb_i = 0;
    chk("drop_nostb", s_rd_stb_o, 0);
    s_rd_ack_i = 4'b0001; s_rd_dat_i[0 +: 32] = 32'h0000_0D0D;
    tick(); s_rd_ack_i = 0;
    chk("drop_ack", {rd_ack_o, rd_dat_o}, {1'b1, 32'h0000_0D0D});
    chk("drop_off", s_rd_adr_o, 1);
    nacks = 0;
    for (int i = 0; i < 20; i++) begin tick(); nacks += rd_ack_o + (s_rd_stb_o != 0); end
    chk("drop_none", nacks, 0);

    // address decode table
    for (int i = 0; i < 6; i++) begin
      s_rd_dat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      ev = s_rd_dat_i[dvec[i].adr[7:4]*32 +: 32];
      if (dvec[i].is_wr) begin
        wr_stb_i = 1; wr_adr_i = dvec[i].adr; wr_sel_i = 4'hF; wr_dat_i = $urandom();
      end else begin
        rd_stb_i = 1; rd_adr_i = dvec[i].adr;
      end
      tick(); idle_in();
      chk("dec_stb", dvec[i].is_wr ? s_wr_stb_o : s_rd_stb_o, dvec[i].exp_stb);
      chk("dec_eack", dvec[i].is_wr ? wr_ack_o : rd_ack_o, dvec[i].exp_err);
      chk("dec_berr", bus_err_o, dvec[i].exp_err);
      if (!dvec[i].exp_err) begin
        if (dvec[i].is_wr) s_wr_ack_i = dvec[i].exp_stb;
        else s_rd_ack_i = dvec[i].exp_stb;
        tick(); idle_in();
        chk("dec_ack", dvec[i].is_wr ? wr_ack_o : rd_ack_o, 1);
        if (!dvec[i].is_wr) chk("dec_rdat", rd_dat_o, ev);
      end else begin
        tick();
      end
    end

    // interrupt masking table
    for (int i = 0; i < 8; i++) begin
      s_int_i = ivec[i].irq;
      tick();
      chk("int_gen", int_gen_o, ivec[i].exp);
    end

    // async reset mid-WAIT
    rd_stb_i = 1; rd_adr_i = 8'h31;
    tick(); rd_stb_i = 0;
    tick(); tick();
    s_int_i = 4'b1111;
    #2 reset_n = 0;
    #1 chk_zero("arst");
    tick(); chk_zero("arst_hold");
    tick();
    reset_n = 1; s_int_i = 0; s_rd_ack_i = 4'b1000;
    tick(); s_rd_ack_i = 0;
    nacks = 0;
    for (int i = 0; i < 20; i++) begin nacks += rd_ack_o + bus_err_o; tick(); end
    chk("arst_noack", nacks, 0);

    // sync reset mid-WAIT on the write channel
    wr_stb_i = 1; wr_adr_i = 8'h22; wr_sel_i = 4'b1100; wr_dat_i = 32'h5A5A_0000;
    tick(); wr_stb_i = 0;
    tick(); sync_reset = 1;
    tick(); sync_reset = 0;
    chk_zero("srst");
    s_wr_ack_i = 4'b0100;
    tick(); s_wr_ack_i = 0;
    nacks = 0;
    for (int i = 0; i < 20; i++) begin nacks += wr_ack_o + bus_err_o; tick(); end
    chk("srst_noack", nacks, 0);

    // randomized traffic against the transaction-level model
    sync_reset = 1; tick(); sync_reset = 0; idle_in(); s_int_i = 0;
    m_rdat = 0; m_wdat = 0; m_roff = 0; m_woff = 0; m_wsel = 0; m_eadr = 0; m_ewr = 0; edat = 0;
    for (int c = 0; c < 2; c++) begin
      pend[c] = 0; late[c] = -1; ackc[c] = -1; slv[c] = 0; due[c] = -1; t0[c] = -10;
      mapd[c] = 0; eerr[c] = 0; eadr[c] = 0;
    end
    cyc = 0;
    for (int it = 0; it < 2500; it++) begin
      idle_in();
      s_rd_dat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && cyc > late[c] && $urandom_range(0, 2) == 0) begin
          int idx, k;
          idx = ($urandom_range(0, 6) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
          k = $urandom_range(1, TO + 2);
          eadr[c] = {idx[3:0], 4'($urandom_range(0, 15))};
          pend[c] = 1; t0[c] = cyc; slv[c] = idx; mapd[c] = (idx < 4);
          if (!mapd[c]) begin
            due[c] = cyc + 1; eerr[c] = 1; ackc[c] = -1;
          end else if (k <= TO) begin
            due[c] = cyc + k + 1; eerr[c] = 0; ackc[c] = cyc + k;
          end else begin
            due[c] = cyc + TO + 1; eerr[c] = 1; ackc[c] = cyc + k; late[c] = cyc + k;
          end
          if (c == 0) begin
            rd_stb_i = 1; rd_adr_i = eadr[c]; m_roff = eadr[c][3:0];
          end else begin
            wr_stb_i = 1; wr_adr_i = eadr[c]; wr_sel_i = 4'($urandom());
            wr_dat_i = $urandom(); m_woff = eadr[c][3:0]; m_wsel = wr_sel_i; m_wdat = wr_dat_i;
          end
        end
        // unrelated slaves chatter; the target slave acks only when scheduled
        m_noise = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0;
        if (slv[c] < 4) m_noise[slv[c]] = (ackc[c] == cyc);
        if (c == 0) s_rd_ack_i = m_noise; else s_wr_ack_i = m_noise;
        if (c == 0 && ackc[c] == cyc && !eerr[c]) edat = s_rd_dat_i[slv[c]*32 +: 32];
      end
      irq = 4'($urandom());
      s_int_i = irq;
      tick();
      cyc++;
      begin
        logic [1:0] eack;
        logic       eber;
        for (int c = 0; c < 2; c++) eack[c] = pend[c] && (due[c] == cyc);
        eber = (eack[0] && eerr[0]) || (eack[1] && eerr[1]);
        if (eack[0]) m_rdat = eerr[0] ? 32'hDEADBEEF : edat;
        if (eack[0] && eerr[0]) begin m_eadr = eadr[0]; m_ewr = 0; end
        else if (eack[1] && eerr[1]) begin m_eadr = eadr[1]; m_ewr = 1; end
        chk("r_acks", {wr_ack_o, rd_ack_o}, eack);
        chk("r_rstb", s_rd_stb_o, (pend[0] && mapd[0] && t0[0] + 1 == cyc) ? (4'b1 << slv[0]) : 4'b0);
        chk("r_wstb", s_wr_stb_o, (pend[1] && mapd[1] && t0[1] + 1 == cyc) ? (4'b1 << slv[1]) : 4'b0);
        chk("r_berr", bus_err_o, eber);
        chk("r_rdat", rd_dat_o, m_rdat);
        chk("r_err", {err_adr_o, err_is_wr_o}, {m_eadr, m_ewr});
        chk("r_wfld", {s_wr_sel_o, s_wr_adr_o, s_wr_dat_o, s_rd_adr_o}, {m_wsel, m_woff, m_wdat, m_roff});
        chk("r_int", int_gen_o, |(irq & IEN));
        for (int c = 0; c < 2; c++) if (eack[c]) pend[c] = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
